// File: rtl/vec_req_arbiter.sv
// Four-way round-robin request arbiter with a one-entry output register,
// outstanding-request credit limit and tagged response demultiplexing.

module vec_req_arbiter_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic       accept_i,
  input  logic [1:0] grant_i,
  input  logic       resp_vld_i,
  input  logic [1:0] resp_tag_i,
  output logic       req_rdy_o,
  output logic       resp_vld_o
);
  assign req_rdy_o  = accept_i && (grant_i == LANE);
  assign resp_vld_o = resp_vld_i && (resp_tag_i == LANE);
endmodule

module vec_req_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_requestor_0_req_valid,
  output logic              io_requestor_0_req_ready,
  input  logic [DATA_W-1:0] io_requestor_0_req_bits,
  output logic              io_requestor_0_resp_valid,
  input  logic              io_requestor_1_req_valid,
  output logic              io_requestor_1_req_ready,
  input  logic [DATA_W-1:0] io_requestor_1_req_bits,
  output logic              io_requestor_1_resp_valid,
  input  logic              io_requestor_2_req_valid,
  output logic              io_requestor_2_req_ready,
  input  logic [DATA_W-1:0] io_requestor_2_req_bits,
  output logic              io_requestor_2_resp_valid,
  input  logic              io_requestor_3_req_valid,
  output logic              io_requestor_3_req_ready,
  input  logic [DATA_W-1:0] io_requestor_3_req_bits,
  output logic              io_requestor_3_resp_valid,
  output logic [DATA_W-1:0] io_requestor_resp_data,
  output logic              io_mem_req_valid,
  input  logic              io_mem_req_ready,
  output logic [DATA_W-1:0] io_mem_req_bits,
  output logic [1:0]        io_mem_req_tag,
  input  logic              io_mem_resp_valid,
  input  logic [1:0]        io_mem_resp_tag,
  input  logic [DATA_W-1:0] io_mem_resp_data,
  output logic              io_err
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]             req_vld, req_rdy, rsp_vld;
  logic [NUM_LANES-1:0][DATA_W-1:0] req_bits;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_bits_q, out_bits_d;
  logic [1:0]        out_tag_q, out_tag_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [3:0]        pending_q, pending_d;
  logic              err_q, err_d;

  logic       load_en, any_vld, accept, found;
  logic [1:0] grant, idx;

  assign req_vld  = {io_requestor_3_req_valid, io_requestor_2_req_valid,
                     io_requestor_1_req_valid, io_requestor_0_req_valid};
  assign req_bits = {io_requestor_3_req_bits, io_requestor_2_req_bits,
                     io_requestor_1_req_bits, io_requestor_0_req_bits};

  // Credit check deliberately uses registered pending: a same-cycle response
  // only frees its credit next cycle, keeping resp_valid off the ready path.
  assign load_en = (!out_valid_q || io_mem_req_ready) && (pending_q < 4'(MAX_OUT));
  assign any_vld = |req_vld;
  assign accept  = load_en && any_vld;

  always_comb begin
    grant = last_grant_q;
    found = 1'b0;
    idx   = last_grant_q;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = last_grant_q + 2'(k);
      if (!found && req_vld[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vec_req_arbiter_lane #(.LANE(2'(g))) u_lane (
      .accept_i   (accept),
      .grant_i    (grant),
      .resp_vld_i (io_mem_resp_valid),
      .resp_tag_i (io_mem_resp_tag),
      .req_rdy_o  (req_rdy[g]),
      .resp_vld_o (rsp_vld[g])
    );
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_bits_d   = out_bits_q;
    out_tag_d    = out_tag_q;
    last_grant_d = last_grant_q;
    pending_d    = pending_q;
    err_d        = err_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_bits_d   = req_bits[grant];
      out_tag_d    = grant;
      last_grant_d = grant;
    end else if (out_valid_q && io_mem_req_ready) begin
      out_valid_d = 1'b0;
    end
    case ({accept, io_mem_resp_valid})
      2'b10: pending_d = pending_q + 4'd1;
      2'b01: begin
        if (pending_q == 4'd0) err_d = 1'b1;
        else                   pending_d = pending_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_bits_q   <= '0;
      out_tag_q    <= 2'd0;
      last_grant_q <= 2'd3;
      pending_q    <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_bits_q   <= out_bits_d;
      out_tag_q    <= out_tag_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
    end
  end

  assign {io_requestor_3_req_ready, io_requestor_2_req_ready,
          io_requestor_1_req_ready, io_requestor_0_req_ready} = req_rdy;
  assign {io_requestor_3_resp_valid, io_requestor_2_resp_valid,
          io_requestor_1_resp_valid, io_requestor_0_resp_valid} = rsp_vld;
  assign io_requestor_resp_data = io_mem_resp_data;
  assign io_mem_req_valid       = out_valid_q;
  assign io_mem_req_bits        = out_bits_q;
  assign io_mem_req_tag         = out_tag_q;
  assign io_err                 = err_q;
endmodule

// File: tb/tb_vec_req_arbiter.sv
// Directed bench for vec_req_arbiter: arbitration order, credits, backpressure,
// response routing, sticky error and asynchronous reset.

module tb_vec_req_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rv;
  logic [31:0] rb [4];
  logic        mready, rsp_v;
  logic [1:0]  rsp_tag;
  logic [31:0] rsp_data;
  wire  [3:0]  rdy, rspv;
  wire  [31:0] resp_data, mbits;
  wire         mvalid, err;
  wire  [1:0]  mtag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vec_req_arbiter #(.DATA_W(32), .MAX_OUT(4)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .io_requestor_0_req_valid  (rv[0]),
    .io_requestor_0_req_ready  (rdy[0]),
    .io_requestor_0_req_bits   (rb[0]),
    .io_requestor_0_resp_valid (rspv[0]),
    .io_requestor_1_req_valid  (rv[1]),
    .io_requestor_1_req_ready  (rdy[1]),
    .io_requestor_1_req_bits   (rb[1]),
    .io_requestor_1_resp_valid (rspv[1]),
    .io_requestor_2_req_valid  (rv[2]),
    .io_requestor_2_req_ready  (rdy[2]),
    .io_requestor_2_req_bits   (rb[2]),
    .io_requestor_2_resp_valid (rspv[2]),
    .io_requestor_3_req_valid  (rv[3]),
    .io_requestor_3_req_ready  (rdy[3]),
    .io_requestor_3_req_bits   (rb[3]),
    .io_requestor_3_resp_valid (rspv[3]),
    .io_requestor_resp_data    (resp_data),
    .io_mem_req_valid          (mvalid),
    .io_mem_req_ready          (mready),
    .io_mem_req_bits           (mbits),
    .io_mem_req_tag            (mtag),
    .io_mem_resp_valid         (rsp_v),
    .io_mem_resp_tag           (rsp_tag),
    .io_mem_resp_data          (rsp_data),
    .io_err                    (err)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; rv = 4'b0; mready = 1'b0; rsp_v = 1'b0; rsp_tag = 2'd0; rsp_data = '0;
    for (int i = 0; i < 4; i++) rb[i] = '0;
    #2;
    chk("rst_valid", 32'(mvalid), 32'd0);
    chk("rst_bits",  mbits,       32'd0);
    chk("rst_tag",   32'(mtag),   32'd0);
    chk("rst_err",   32'(err),    32'd0);
    chk("rst_rdy",   32'(rdy),    32'd0);
    chk("rst_rspv",  32'(rspv),   32'd0);
    tick();
    reset = 1'b1;

    // single request from requestor 2
    rv = 4'b0100; rb[2] = 32'h55; mready = 1'b1;
    #1 chk("single_rdy", 32'(rdy), 32'b0100);
    tick();
    rv = 4'b0;
    #1;
    chk("single_valid", 32'(mvalid), 32'd1);
    chk("single_bits",  mbits,       32'h55);
    chk("single_tag",   32'(mtag),   32'd2);
    // response routing; also drains the register and answers the one request
    rsp_v = 1'b1; rsp_tag = 2'd1; rsp_data = 32'hABCD;
    #1;
    chk("route_rspv", 32'(rspv),  32'b0010);
    chk("route_data", resp_data,  32'hABCD);
    tick();
    rsp_v = 1'b0;
    #1;
    chk("drain_valid", 32'(mvalid), 32'd0);
    chk("route_noerr", 32'(err),    32'd0);

    // round robin to the credit limit
    apply_reset();
    rv = 4'b1111; mready = 1'b1;
    for (int i = 0; i < 4; i++) rb[i] = 32'h100 + 32'(i);
    #1 chk("rr_rdy0", 32'(rdy), 32'b0001);
    for (int g = 0; g < 4; g++) begin
      tick();
      #1;
      chk("rr_tag",   32'(mtag),   32'(g));
      chk("rr_bits",  mbits,       32'h100 + 32'(g));
      chk("rr_valid", 32'(mvalid), 32'd1);
      chk("rr_rdy",   32'(rdy),    (g < 3) ? (32'd1 << (g + 1)) : 32'd0);
    end
    tick();
    #1;
    chk("credit_drained", 32'(mvalid), 32'd0);
    chk("credit_rdy",     32'(rdy),    32'd0);
    rsp_v = 1'b1; rsp_tag = 2'd0;
    #1 chk("credit_samecyc", 32'(rdy), 32'd0);
    tick();
    rsp_v = 1'b0;
    #1 chk("credit_freed", 32'(rdy), 32'b0001);
    tick();
    #1;
    chk("credit_tag",  32'(mtag), 32'd0);
    chk("credit_bits", mbits,     32'h100);

    // backpressure: free three credits, then hold with the register full
    mready = 1'b0; rsp_v = 1'b1; rsp_tag = 2'd0;
    repeat (3) tick();
    rsp_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rdy",   32'(rdy),    32'd0);
      chk("bp_bits",  mbits,       32'h100);
      chk("bp_tag",   32'(mtag),   32'd0);
      chk("bp_valid", 32'(mvalid), 32'd1);
      tick();
    end
    mready = 1'b1;
    #1 chk("bp_release_rdy", 32'(rdy), 32'b0010);
    tick();
    #1;
    chk("bp_load_tag",   32'(mtag),   32'd1);
    chk("bp_load_bits",  mbits,       32'h101);
    chk("bp_load_valid", 32'(mvalid), 32'd1);

    // accept and response together: pending stays at 2
    rsp_v = 1'b1; rsp_tag = 2'd3; rsp_data = 32'h1234;
    #1;
    chk("sim_rspv", 32'(rspv), 32'b1000);
    chk("sim_data", resp_data, 32'h1234);
    chk("sim_rdy",  32'(rdy),  32'b0100);
    tick();
    rsp_v = 1'b0; rv = 4'b0001;
    #1 chk("sim_rdy_p2", 32'(rdy), 32'b0001);
    tick();
    #1;
    chk("sim_rdy_p3", 32'(rdy),  32'b0001);
    chk("sim_tag",    32'(mtag), 32'd0);
    tick();
    #1 chk("sim_rdy_p4", 32'(rdy), 32'd0);

    // response with nothing pending
    apply_reset();
    rv = 4'b0; rsp_v = 1'b1; rsp_tag = 2'd0;
    #1 chk("err_samecyc", 32'(err), 32'd0);
    tick();
    rsp_v = 1'b0;
    #1 chk("err_set", 32'(err), 32'd1);
    repeat (3) tick();
    chk("err_sticky", 32'(err), 32'd1);
    rv = 4'b1110; mready = 1'b1;
    #1 chk("err_pend0_rdy1", 32'(rdy), 32'b0010);
    tick();
    #1 chk("err_pend1_rdy2", 32'(rdy), 32'b0100);
    tick();
    #1 chk("err_pend2_rdy3", 32'(rdy), 32'b1000);
    tick();
    rv = 4'b0; mready = 1'b0;
    #1;
    chk("mid_valid_pre", 32'(mvalid), 32'd1);
    chk("mid_tag_pre",   32'(mtag),   32'd3);
    chk("mid_err_pre",   32'(err),    32'd1);

    // asynchronous reset between clock edges
    #1 reset = 1'b0;
    #1;
    chk("mid_valid", 32'(mvalid), 32'd0);
    chk("mid_err",   32'(err),    32'd0);
    chk("mid_tag",   32'(mtag),   32'd0);
    #1 reset = 1'b1;
    rv = 4'b1111; mready = 1'b1;
    #1 chk("mid_first_rdy", 32'(rdy), 32'b0001);
    tick();
    #1;
    chk("mid_first_tag",   32'(mtag),   32'd0);
    chk("mid_first_bits",  mbits,       32'h100);
    chk("mid_first_valid", 32'(mvalid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vec_req_arbiter.md
# vec_req_arbiter

Four-way round-robin request arbiter with a one-entry output register and response demultiplexing. It sits directly upstream of the memory-side selection stage: it collects the four `io_requestor_N_req` ready/valid streams, serialises them onto one `io_mem_req` port tagged with the source index, and routes tagged responses back to the originating requestor. An outstanding-request credit counter limits how many requests may be in flight.

## Interface
- `DATA_W`, default 32: width of request payload and response data.
- `MAX_OUT`, default 4: maximum requests accepted but not yet answered (1..15).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_requestor_N_req_valid`  in  1  request from requestor N (N = 0..3).
- `io_requestor_N_req_ready`  out  1  request N accepted this cycle.
- `io_requestor_N_req_bits`  in  DATA_W  request payload N.
- `io_requestor_N_resp_valid`  out  1  response for requestor N.
- `io_requestor_resp_data`  out  DATA_W  response data, shared by all requestors.
- `io_mem_req_valid`  out  1  output register holds a request.
- `io_mem_req_ready`  in  1  downstream accepts.
- `io_mem_req_bits`  out  DATA_W  registered payload.
- `io_mem_req_tag`  out  2  source index of the registered request.
- `io_mem_resp_valid`  in  1  response present.
- `io_mem_resp_tag`  in  2  destination requestor.
- `io_mem_resp_data`  in  DATA_W  response data.
- `io_err`  out  1  sticky protocol error.

## Operation
- **State:**
  - `out_valid`, `out_bits`, `out_tag`: output register.
  - `last_grant` (2 b): index of the most recent grant.
  - `pending` (4 b): accepted-but-unanswered count.
  - `err`: sticky error flag.
- **Reset values:** `out_valid`=0, `out_bits`=0, `out_tag`=0, `last_grant`=3 (so requestor 0 has first priority), `pending`=0, `err`=0. The outputs `io_mem_req_valid`, `io_mem_req_bits`, `io_mem_req_tag` and `io_err` are therefore 0, and all `req_ready` and `resp_valid` outputs are 0 because the request and response inputs are 0.
- **Load enable:** `load_en` = (!`out_valid` || `io_mem_req_ready`) && (`pending` < `MAX_OUT`).
- **Grant:** `grant` = first valid requestor, scanning `last_grant`+1, +2, +3, +4 (mod 4).
  - `io_requestor_N_req_ready` = `load_en` && any valid && (N == `grant`).
  - At most one `req_ready` is high per cycle.
- **On accept:**
  - `out_valid` <= 1, `out_bits` <= payload, `out_tag` <= `grant`, `last_grant` <= `grant`.
- **On drain without accept:** (`out_valid` && `io_mem_req_ready`) with no accept, `out_valid` <= 0.
- **When `io_mem_req_ready`=0 and the register is full:** `out_bits` and `out_tag` hold stable and `out_valid` stays 1.
- **Pending counter:**
  - Increment on accept; decrement on `io_mem_resp_valid`.
  - Both in the same cycle: unchanged.
  - A response with `pending`=0 (and no simultaneous accept) leaves `pending` at 0 and sets `err`.
- **`err`:** cleared only by reset.
- **Response demux** (combinational):
  - `io_requestor_N_resp_valid` = `io_mem_resp_valid` && (`io_mem_resp_tag` == N).
  - `io_requestor_resp_data` = `io_mem_resp_data`.
  - Responses have no backpressure.
- **Credit check:** the credit check uses the registered `pending`. A response arriving in the same cycle does not free a credit until the next cycle.

## Timing
- **Request latency:** accepted in cycle T, presented on `io_mem_req_*` in cycle T+1.
- **Throughput:** one request per cycle while `io_mem_req_ready`=1 and credits remain.
- **Ready path:** `req_ready` is combinational from `io_mem_req_ready`, all `req_valid` inputs and state. Requestors must not make `req_valid` depend on `req_ready`.
- **Response path:** combinational, zero latency.
- **Reset mid-operation:** asynchronous assertion immediately forces `out_valid`=0 and clears `pending` and `err`. Any buffered request is dropped. Release is synchronised by the integrator.

## Test plan
- **Single request:** after reset, `req_valid` on requestor 2 only, bits 0x55, `io_mem_req_ready`=1 → `io_requestor_2_req_ready`=1 that cycle; next cycle `io_mem_req_valid`=1, bits=0x55, tag=2.
- **Round-robin and credit limit:** all four valid continuously, `io_mem_req_ready`=1, no responses, `MAX_OUT`=4 → grants 0,1,2,3 on consecutive cycles; fifth cycle all `req_ready`=0 with `pending`=4. One response then permits grant 0 the following cycle.
- **Backpressure:** register full, `io_mem_req_ready`=0 for 5 cycles with requestors valid → all `req_ready`=0; `io_mem_req_bits` and tag unchanged. Raising ready gives a drain and a new load in the same cycle.
- **Response routing:** `io_mem_resp_valid`=1, tag=1, data=0xABCD → only `io_requestor_1_resp_valid`=1 and data=0xABCD. A simultaneous accept leaves `pending` unchanged.
- **Error flag:** response with `pending`=0 → `io_err`=1 on the next cycle; it stays 1 until reset, and `pending` stays 0.
- **Reset mid-operation:** `reset` low with `out_valid`=1 and `pending`=3 → `io_mem_req_valid`=0 and `io_err`=0 immediately. After release, the first grant goes to requestor 0.
